dm_arbiter: RTL and testbench

Two-port arbiter and sequencer placed in front of the single-ported data memory (DM). It accepts load/store commands from two requesters: port 0 is the pipeline MEM stage, port 1 is a secondary master such as a debug or DMA port. It serialises those commands onto the DM's MemWrite/MemRead/Addr/WD/WPC interface and returns read data to the requester that issued each load. Port 0 has fixed priority, and a starvation counter guarantees port 1 forward progress.

---
 rtl/dm_arbiter.sv | 143 ++++++++++++++
 tb/tb_dm_arbiter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_arbiter.sv
// dm_arbiter: serialises load/store commands from two requesters onto a single-ported data memory.
// Port 0 has fixed priority; a saturating wait counter forces port 1 ahead after MAX_WAIT refusals.
module dm_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Req0,
    input  logic              Req1,
    input  logic              We0,
    input  logic              We1,
    input  logic [ADDR_W-1:0] Addr0,
    input  logic [ADDR_W-1:0] Addr1,
    input  logic [DATA_W-1:0] WD0,
    input  logic [DATA_W-1:0] WD1,
    input  logic [31:0]       PC0,
    input  logic [31:0]       PC1,
    output logic              Gnt0,
    output logic              Gnt1,
    output logic              RValid0,
    output logic              RValid1,
    output logic [DATA_W-1:0] RD0,
    output logic [DATA_W-1:0] RD1,
    output logic              MemWrite,
    output logic              MemRead,
    output logic [ADDR_W-1:0] Addr,
    output logic [DATA_W-1:0] WD,
    output logic [31:0]       WPC,
    input  logic [DATA_W-1:0] RD
);
    typedef enum logic {S_IDLE = 1'b0, S_ACCESS = 1'b1} state_t;

    localparam logic [7:0] WAIT_MAX = 8'(MAX_WAIT);

    state_t            state_q, state_d;
    logic              owner_q, owner_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wd_q, wd_d;
    logic [31:0]       pc_q, pc_d;
    logic [7:0]        wait_q, wait_d;
    logic [DATA_W-1:0] rd0_q, rd0_d, rd1_q, rd1_d;
    logic              rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
    logic              idle, force1, gnt0, gnt1;

    // Grants are only offered in IDLE and are forced low while reset is held.
    always_comb begin
        idle   = (state_q == S_IDLE);
        force1 = Req1 && (wait_q == WAIT_MAX);
        gnt1   = Reset && idle && Req1 && (force1 || !Req0);
        gnt0   = Reset && idle && Req0 && !force1;
    end

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wd_d      = wd_q;
        pc_d      = pc_q;
        rd0_d     = rd0_q;
        rd1_d     = rd1_q;
        rvalid0_d = 1'b0;
        rvalid1_d = 1'b0;
        wait_d    = wait_q;

        case (state_q)
            S_IDLE: begin
                if (gnt0 || gnt1) begin
                    state_d = S_ACCESS;
                    owner_d = gnt1;
                    we_d    = gnt1 ? We1   : We0;
                    addr_d  = gnt1 ? Addr1 : Addr0;
                    wd_d    = gnt1 ? WD1   : WD0;
                    pc_d    = gnt1 ? PC1   : PC0;
                end
            end
            S_ACCESS: begin
                state_d = S_IDLE;
                if (!we_q) begin
                    if (owner_q) begin
                        rd1_d     = RD;
                        rvalid1_d = 1'b1;
                    end else begin
                        rd0_d     = RD;
                        rvalid0_d = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Port 1 accrues wait in both states whenever it is requesting but not granted.
        if (!Req1 || gnt1) begin
            wait_d = 8'd0;
        end else if (wait_q < WAIT_MAX) begin
            wait_d = wait_q + 8'd1;
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q   <= S_IDLE;
            owner_q   <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wd_q      <= '0;
            pc_q      <= '0;
            wait_q    <= 8'd0;
            rd0_q     <= '0;
            rd1_q     <= '0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wd_q      <= wd_d;
            pc_q      <= pc_d;
            wait_q    <= wait_d;
            rd0_q     <= rd0_d;
            rd1_q     <= rd1_d;
            rvalid0_q <= rvalid0_d;
            rvalid1_q <= rvalid1_d;
        end
    end

    assign Gnt0     = gnt0;
    assign Gnt1     = gnt1;
    assign RValid0  = rvalid0_q;
    assign RValid1  = rvalid1_q;
    assign RD0      = rd0_q;
    assign RD1      = rd1_q;
    assign MemWrite = (state_q == S_ACCESS) && we_q;
    assign MemRead  = (state_q == S_ACCESS) && !we_q;
    assign Addr     = addr_q;
    assign WD       = wd_q;
    assign WPC      = pc_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// Self-checking bench for dm_arbiter: directed scenarios plus randomized traffic
// compared against a transaction-level model of arbitration and memory contents.
module tb_dm_arbiter;
    localparam int ADDR_W   = 32;
    localparam int DATA_W   = 32;
    localparam int MAX_WAIT = 4;

    logic        Clock = 1'b0;
    logic        Reset = 1'b0;
    logic        Req0 = 1'b0, Req1 = 1'b0, We0 = 1'b0, We1 = 1'b0;
    logic [31:0] Addr0 = '0, Addr1 = '0, WD0 = '0, WD1 = '0, PC0 = '0, PC1 = '0;
    logic        Gnt0, Gnt1, RValid0, RValid1, MemWrite, MemRead;
    logic [31:0] RD0, RD1, Addr, WD, WPC, RD;

    logic [31:0] mem [0:1023];
    logic        clr_mem = 1'b0, pre_we = 1'b0;
    logic [9:0]  pre_idx = '0;
    logic [31:0] pre_data = '0;

    int n_cmp  = 0;
    int n_fail = 0;

    dm_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT)) dut (
        .Clock(Clock), .Reset(Reset),
        .Req0(Req0), .Req1(Req1), .We0(We0), .We1(We1),
        .Addr0(Addr0), .Addr1(Addr1), .WD0(WD0), .WD1(WD1), .PC0(PC0), .PC1(PC1),
        .Gnt0(Gnt0), .Gnt1(Gnt1), .RValid0(RValid0), .RValid1(RValid1),
        .RD0(RD0), .RD1(RD1), .MemWrite(MemWrite), .MemRead(MemRead),
        .Addr(Addr), .WD(WD), .WPC(WPC), .RD(RD)
    );

    always #5 Clock = ~Clock;

    // Data memory: combinational read, write committed on the rising edge.
    assign RD = mem[Addr[11:2]];
    always @(posedge Clock) begin
        if (clr_mem) begin
            for (int i = 0; i < 1024; i++) mem[i] <= '0;
        end else if (pre_we) begin
            mem[pre_idx] <= pre_data;
        end else if (MemWrite) begin
            mem[Addr[11:2]] <= WD;
        end
    end

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic test_reset();
        Reset = 1'b0; Req0 = 1'b0; Req1 = 1'b0; clr_mem = 1'b1;
        tick();
        clr_mem = 1'b0;
        tick();
        #1;
        n_cmp++; if ({Gnt0, Gnt1, RValid0, RValid1, MemWrite, MemRead} !== 6'b0) begin n_fail++; $display("FAIL rst_ctl: got %b want 000000", {Gnt0, Gnt1, RValid0, RValid1, MemWrite, MemRead}); end
        n_cmp++; if ({Addr, WD, WPC} !== 96'b0) begin n_fail++; $display("FAIL rst_dm_bus: got %h %h %h want 0", Addr, WD, WPC); end
        n_cmp++; if ({RD0, RD1} !== 64'b0) begin n_fail++; $display("FAIL rst_rd: got %h %h want 0", RD0, RD1); end
        Req0 = 1'b1; Req1 = 1'b1;
        #1;
        n_cmp++; if ({Gnt0, Gnt1} !== 2'b00) begin n_fail++; $display("FAIL rst_gnt_gated: got %b want 00", {Gnt0, Gnt1}); end
        Req0 = 1'b0; Req1 = 1'b0;
        tick();
        Reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++; if ({MemWrite, MemRead, RValid0, RValid1} !== 4'b0) begin n_fail++; $display("FAIL rst_idle_%0d: got %b want 0000", i, {MemWrite, MemRead, RValid0, RValid1}); end
        end
    endtask

    task automatic test_store_load_p0();
        tick();
        Req0 = 1'b1; We0 = 1'b1; Addr0 = 32'h10; WD0 = 32'hDEADBEEF; PC0 = 32'h3000;
        #1;
        n_cmp++; if ({Gnt0, Gnt1} !== 2'b10) begin n_fail++; $display("FAIL sl_st_gnt: got %b want 10", {Gnt0, Gnt1}); end
        tick();
        Req0 = 1'b0;
        #1;
        n_cmp++; if ({MemWrite, MemRead, Gnt0} !== 3'b100) begin n_fail++; $display("FAIL sl_st_access: got %b want 100", {MemWrite, MemRead, Gnt0}); end
        n_cmp++; if ({Addr, WD, WPC} !== {32'h10, 32'hDEADBEEF, 32'h3000}) begin n_fail++; $display("FAIL sl_st_bus: got %h %h %h want 10 deadbeef 3000", Addr, WD, WPC); end
        tick();
        n_cmp++; if ({MemWrite, RValid0, RValid1} !== 3'b000) begin n_fail++; $display("FAIL sl_st_done: got %b want 000", {MemWrite, RValid0, RValid1}); end
        Req0 = 1'b1; We0 = 1'b0; Addr0 = 32'h10; WD0 = 32'h0; PC0 = 32'h3004;
        #1;
        n_cmp++; if (Gnt0 !== 1'b1) begin n_fail++; $display("FAIL sl_ld_gnt: got %b want 1", Gnt0); end
        tick();
        Req0 = 1'b0;
        n_cmp++; if ({MemWrite, MemRead} !== 2'b01) begin n_fail++; $display("FAIL sl_ld_access: got %b want 01", {MemWrite, MemRead}); end
        tick();
        n_cmp++; if ({RValid0, RValid1} !== 2'b10) begin n_fail++; $display("FAIL sl_ld_rvalid: got %b want 10", {RValid0, RValid1}); end
        n_cmp++; if (RD0 !== 32'hDEADBEEF) begin n_fail++; $display("FAIL sl_ld_rd0: got %h want deadbeef", RD0); end
        tick();
        n_cmp++; if ({RValid0, RValid1} !== 2'b00) begin n_fail++; $display("FAIL sl_rvalid_pulse: got %b want 00", {RValid0, RValid1}); end
        n_cmp++; if (RD0 !== 32'hDEADBEEF) begin n_fail++; $display("FAIL sl_rd0_hold: got %h want deadbeef", RD0); end
    endtask

    task automatic test_simultaneous();
        tick();
        pre_we = 1'b1; pre_idx = 10'd1023; pre_data = 32'd1024;
        tick();
        pre_idx = 10'd0; pre_data = 32'h55;
        tick();
        pre_we = 1'b0;
        Req0 = 1'b1; We0 = 1'b0; Addr0 = 32'h0;   PC0 = 32'h100;
        Req1 = 1'b1; We1 = 1'b0; Addr1 = 32'hFFC; PC1 = 32'h200;
        #1;
        n_cmp++; if ({Gnt0, Gnt1} !== 2'b10) begin n_fail++; $display("FAIL sim_first: got %b want 10", {Gnt0, Gnt1}); end
        tick();
        Req0 = 1'b0;
        #1;
        n_cmp++; if ({Gnt0, Gnt1, MemRead} !== 3'b001) begin n_fail++; $display("FAIL sim_access0: got %b want 001", {Gnt0, Gnt1, MemRead}); end
        tick();
        n_cmp++; if ({RValid0, RValid1, RD0} !== {2'b10, 32'h55}) begin n_fail++; $display("FAIL sim_rd0: got %b %h want 10 55", {RValid0, RValid1}, RD0); end
        n_cmp++; if ({Gnt0, Gnt1} !== 2'b01) begin n_fail++; $display("FAIL sim_second: got %b want 01", {Gnt0, Gnt1}); end
        tick();
        Req1 = 1'b0;
        n_cmp++; if ({Addr, WPC, MemRead} !== {32'hFFC, 32'h200, 1'b1}) begin n_fail++; $display("FAIL sim_access1: got %h %h %b want ffc 200 1", Addr, WPC, MemRead); end
        tick();
        n_cmp++; if ({RValid0, RValid1, RD1} !== {2'b01, 32'd1024}) begin n_fail++; $display("FAIL sim_rd1: got %b %0d want 01 1024", {RValid0, RValid1}, RD1); end
        n_cmp++; if (RD0 !== 32'h55) begin n_fail++; $display("FAIL sim_rd0_kept: got %h want 55", RD0); end
    endtask

    task automatic test_starvation();
        int first = -1;
        int second = -1;
        tick();
        Req0 = 1'b1; We0 = 1'b0; Addr0 = 32'h0;
        Req1 = 1'b1; We1 = 1'b0; Addr1 = 32'hFFC;
        for (int c = 0; c < 20; c++) begin
            #1;
            n_cmp++; if (Gnt0 && Gnt1) begin n_fail++; $display("FAIL stv_onehot: cycle %0d both grants high", c); end
            if (Gnt1) begin
                if (first < 0) first = c;
                else if (second < 0) second = c;
            end
            tick();
        end
        Req0 = 1'b0; Req1 = 1'b0;
        n_cmp++; if (first != 4) begin n_fail++; $display("FAIL stv_first_grant: got cycle %0d want 4", first); end
        n_cmp++; if (first < 0 || first >= 2 * (MAX_WAIT + 1)) begin n_fail++; $display("FAIL stv_bound: got cycle %0d want < %0d", first, 2 * (MAX_WAIT + 1)); end
        n_cmp++; if (second - first != 6) begin n_fail++; $display("FAIL stv_wait_cleared: got gap %0d want 6", second - first); end
        tick();
        tick();
    endtask

    task automatic test_reset_mid_store();
        tick();
        Req1 = 1'b1; We1 = 1'b1; Addr1 = 32'h8; WD1 = 32'd100; PC1 = 32'h4000;
        #1;
        n_cmp++; if (Gnt1 !== 1'b1) begin n_fail++; $display("FAIL rms_gnt: got %b want 1", Gnt1); end
        tick();
        Req1 = 1'b0;
        #1;
        n_cmp++; if (MemWrite !== 1'b1) begin n_fail++; $display("FAIL rms_write: got %b want 1", MemWrite); end
        #2;
        Reset = 1'b0;
        #1;
        n_cmp++; if ({MemWrite, MemRead} !== 2'b00) begin n_fail++; $display("FAIL rms_abort: got %b want 00", {MemWrite, MemRead}); end
        tick();
        Reset = 1'b1;
        n_cmp++; if (RValid1 !== 1'b0) begin n_fail++; $display("FAIL rms_rvalid1: got %b want 0", RValid1); end
        tick();
        Req0 = 1'b1; We0 = 1'b0; Addr0 = 32'h8;
        tick();
        Req0 = 1'b0;
        tick();
        n_cmp++; if ({RValid0, RD0} !== {1'b1, 32'd0}) begin n_fail++; $display("FAIL rms_old_value: got %b %0d want 1 0", RValid0, RD0); end
    endtask

    task automatic test_p1_store_keeps_rd0();
        tick();
        Req0 = 1'b1; We0 = 1'b0; Addr0 = 32'hFFC;
        tick();
        Req0 = 1'b0;
        tick();
        n_cmp++; if ({RValid0, RD0} !== {1'b1, 32'd1024}) begin n_fail++; $display("FAIL ps_load: got %b %0d want 1 1024", RValid0, RD0); end
        Req1 = 1'b1; We1 = 1'b1; Addr1 = 32'h20; WD1 = 32'h77; PC1 = 32'h5000;
        for (int i = 0; i < 4; i++) begin
            #1;
            if (Gnt1) Req1 = 1'b0;
            tick();
            n_cmp++; if ({RValid0, RValid1, RD0} !== {2'b00, 32'd1024}) begin n_fail++; $display("FAIL ps_hold_%0d: got %b %0d want 00 1024", i, {RValid0, RValid1}, RD0); end
        end
    endtask

    task automatic test_random();
        logic [31:0] mm [0:15];
        logic [31:0] acc_addr = '0, acc_wd = '0, acc_pc = '0, acc_data = '0, rd0 = '0, rd1 = '0, off;
        bit p0 = 0, p1 = 0, acc_v = 0, acc_we = 0, acc_port = 0, rv0 = 0, rv1 = 0, eg0, eg1;
        int wait_m = 0;
        for (int i = 0; i < 16; i++) mm[i] = '0;
        Req0 = 1'b0; Req1 = 1'b0; Reset = 1'b0; clr_mem = 1'b1;
        tick();
        clr_mem = 1'b0; Reset = 1'b1;
        for (int c = 0; c < 600; c++) begin
            n_cmp++; if ({RValid0, RValid1} !== {rv0, rv1}) begin n_fail++; $display("FAIL rnd_rvalid c%0d: got %b want %b", c, {RValid0, RValid1}, {rv0, rv1}); end
            n_cmp++; if ({RD0, RD1} !== {rd0, rd1}) begin n_fail++; $display("FAIL rnd_rd c%0d: got %h %h want %h %h", c, RD0, RD1, rd0, rd1); end
            n_cmp++; if ({MemWrite, MemRead} !== {acc_v && acc_we, acc_v && !acc_we}) begin n_fail++; $display("FAIL rnd_memctl c%0d: got %b want %b", c, {MemWrite, MemRead}, {acc_v && acc_we, acc_v && !acc_we}); end
            if (acc_v) begin
                n_cmp++; if ({Addr, WD, WPC} !== {acc_addr, acc_wd, acc_pc}) begin n_fail++; $display("FAIL rnd_bus c%0d: got %h %h %h want %h %h %h", c, Addr, WD, WPC, acc_addr, acc_wd, acc_pc); end
            end
            if (!p0 && $urandom_range(0, 99) < 70) begin
                p0 = 1; We0 = 1'($urandom_range(0, 1)); Addr0 = 32'h100 + ($urandom_range(0, 15) << 2); WD0 = $urandom; PC0 = $urandom;
            end
            if (!p1 && $urandom_range(0, 99) < 45) begin
                p1 = 1; We1 = 1'($urandom_range(0, 1)); Addr1 = 32'h100 + ($urandom_range(0, 15) << 2); WD1 = $urandom; PC1 = $urandom;
            end
            Req0 = p0; Req1 = p1;
            #1;
            // Expected arbitration: no grant mid-access; port 1 wins once it has waited MAX_WAIT cycles.
            eg1 = !acc_v && p1 && (wait_m >= MAX_WAIT || !p0);
            eg0 = !acc_v && p0 && !eg1;
            n_cmp++; if ({Gnt0, Gnt1} !== {eg0, eg1}) begin n_fail++; $display("FAIL rnd_gnt c%0d: got %b want %b", c, {Gnt0, Gnt1}, {eg0, eg1}); end
            rv0 = acc_v && !acc_we && !acc_port;
            rv1 = acc_v && !acc_we && acc_port;
            if (rv0) rd0 = acc_data;
            if (rv1) rd1 = acc_data;
            wait_m = (!p1 || eg1) ? 0 : ((wait_m < MAX_WAIT) ? wait_m + 1 : wait_m);
            acc_v = eg0 || eg1;
            if (acc_v) begin
                acc_port = eg1;
                acc_we   = eg1 ? We1   : We0;
                acc_addr = eg1 ? Addr1 : Addr0;
                acc_wd   = eg1 ? WD1   : WD0;
                acc_pc   = eg1 ? PC1   : PC0;
                off      = acc_addr - 32'h100;
                if (acc_we) mm[off[5:2]] = acc_wd;
                else acc_data = mm[off[5:2]];
            end
            if (eg0) p0 = 0;
            if (eg1) p1 = 0;
            tick();
        end
        Req0 = 1'b0; Req1 = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        test_reset();
        test_store_load_p0();
        test_simultaneous();
        test_starvation();
        test_reset_mid_store();
        test_p1_store_keeps_rd0();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
